mem_access_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 26 ++
 rtl/mau_lane.sv | 49 ++++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store unit: access size codes,
// the access FSM state encoding and the default memory geometry.
package mem_pkg;

    // Default geometry of the downstream data memory (32-bit words).
    localparam int MEM_WORDS = 32;
    localparam int IDX_W     = 5;

    // Access size as presented on the CPU side.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Access sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } mau_state_e;

endpackage

// File: rtl/mau_lane.sv
// Byte/halfword lane handling for the load/store unit: pulls the addressed
// lane out of a memory word and extends it for loads, and splices store
// data into the addressed lane of a memory word for read-modify-write.
module mau_lane
    import mem_pkg::*;
(
    input  size_e       size_i,
    input  logic        uns_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rword_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_bit;

    // Lane extract/extend and lane merge; word accesses pass the word through.
    always_comb begin
        byte_sel = rword_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        sign_bit = 1'b0;
        load_o   = rword_i;
        merge_o  = rword_i;
        case (size_i)
            SZ_BYTE: begin
                sign_bit = ~uns_i & byte_sel[7];
                load_o   = {{24{sign_bit}}, byte_sel};
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                sign_bit = ~uns_i & half_sel[15];
                load_o   = {{16{sign_bit}}, half_sel};
                if (lane_i[1]) begin
                    merge_o[31:16] = wdata_i;
                end else begin
                    merge_o[15:0] = wdata_i;
                end
            end
            default: begin
                load_o  = rword_i;
                merge_o = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit in front of a word-wide synchronous data memory.
// Handles byte/halfword/word accesses, sign/zero extension of loads and
// read-modify-write for sub-word stores; misaligned or out-of-range
// accesses complete immediately with err set and touch no memory.
//
// Handshake: req is sampled only when the unit is idle (busy=0); the
// sampled command is latched and later req values are ignored until the
// unit is idle again. Completion is a single-cycle done pulse with err
// valid in that same cycle; busy is high from the cycle after sampling
// up to and including the done cycle. done never lasts two cycles.
module mem_access_unit #(
    parameter int MEM_WORDS = mem_pkg::MEM_WORDS,
    parameter int IDX_W     = mem_pkg::IDX_W
) (
    input  logic        MEM_clk,
    input  logic        MEM_rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_WrEn,
    output logic [31:0] mem_Adr,
    output logic [31:0] mem_DataIn,
    input  logic [31:0] mem_DataOut,
    output logic [2:0]  dbg_state_o
);

    import mem_pkg::*;

    mau_state_e       state_q;
    logic             we_q;
    size_e            size_q;
    logic             uns_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic [31:0]      merge_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;

    logic             illegal_d;
    logic [31:0]      load_val;
    logic [31:0]      merge_val;

    // Legality of the incoming command: size code, alignment, and an index
    // that must fall inside the attached memory.
    always_comb begin
        illegal_d = 1'b0;
        case (size_e'(size))
            SZ_BYTE: illegal_d = 1'b0;
            SZ_HALF: illegal_d = addr[0];
            SZ_WORD: illegal_d = (addr[1:0] != 2'b00);
            default: illegal_d = 1'b1;
        endcase
        if ((addr >> (IDX_W + 2)) != 32'd0) begin
            illegal_d = 1'b1;
        end
        if ({1'b0, addr[IDX_W+1:2]} >= (IDX_W + 1)'(MEM_WORDS)) begin
            illegal_d = 1'b1;
        end
    end

    mau_lane u_lane (
        .size_i  (size_q),
        .uns_i   (uns_q),
        .lane_i  (addr_q[1:0]),
        .rword_i (mem_DataOut),
        .wdata_i (wdata_q[15:0]),
        .load_o  (load_val),
        .merge_o (merge_val)
    );

    // Access sequencer with command latches and registered status outputs.
    always_ff @(posedge MEM_clk) begin
        if (MEM_rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size_e'(size);
                        uns_q   <= uns;
                        addr_q  <= addr[IDX_W+1:0];
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (illegal_d) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (we && (size_e'(size) == SZ_WORD)) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    // Memory sees the latched index now; its word is valid in CAP.
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    if (we_q) begin
                        merge_q <= merge_val;
                        state_q <= ST_WR;
                    end else begin
                        rdata_q <= load_val;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_WR: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

    // The write strobe drops immediately on reset so an interrupted WR never lands.
    assign mem_WrEn   = (state_q == ST_WR) & ~MEM_rst;
    assign mem_Adr    = {{(32 - IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
    assign mem_DataIn = (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a synchronous word memory model, a table of
// access vectors checked through an expected-result queue, and directed
// sequences for reset during a write and continuously held requests.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic        mem_WrEn;
    logic [31:0] mem_Adr;
    logic [31:0] mem_DataIn;
    logic [31:0] mem_DataOut = '0;
    logic [2:0]  dbg_state;

    logic [31:0] mem [32];
    logic        bd_we = 1'b0;
    logic [4:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    int          wr_cnt = 0;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          writes;
        int          chk_idx;
        logic [31:0] chk_word;
    } vec_t;

    vec_t vt[16];

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    mem_access_unit #(.MEM_WORDS(32), .IDX_W(5)) dut (
        .MEM_clk     (clk),
        .MEM_rst     (rst),
        .req         (req),
        .we          (we),
        .size        (size),
        .uns         (uns),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .mem_WrEn    (mem_WrEn),
        .mem_Adr     (mem_Adr),
        .mem_DataIn  (mem_DataIn),
        .mem_DataOut (mem_DataOut),
        .dbg_state_o (dbg_state)
    );

    // Synchronous data memory model with a backdoor preload port
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_WrEn) begin
            mem[mem_Adr[4:0]] <= mem_DataIn;
        end
        mem_DataOut <= mem[mem_Adr[4:0]];
        if (mem_WrEn) begin
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] init_word(input int i);
        case (i)
            1:       return 32'h1111_1111;
            2:       return 32'h2222_2222;
            3:       return 32'h80FF_1234;
            5:       return 32'h0123_4567;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int lat, input logic e, input logic [31:0] rd,
                                input int wr, input int ci, input logic [31:0] cw);
        vec_t v;
        v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.lat = lat; v.err = e; v.rdata = rd; v.writes = wr;
        v.chk_idx = ci; v.chk_word = cw;
        return v;
    endfunction

    // Driver and checker tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int          cyc;
        int          wr0;
        logic [32:0] e;
        wait_idle();
        wr0   = wr_cnt;
        req   = 1'b1;
        we    = v.we;
        size  = v.size;
        uns   = v.uns;
        addr  = v.addr;
        wdata = v.wdata;
        exp_q.push_back({v.err, v.rdata});
        cyc = 0;
        do begin
            @(posedge clk); #1;
            req = 1'b0;
            cyc++;
        end while (!done && cyc < 12);
        check($sformatf("v%0d_latency", k), 32'(cyc), 32'(v.lat));
        e = exp_q.pop_front();
        check($sformatf("v%0d_done", k), 32'(done), 32'd1);
        check($sformatf("v%0d_err", k), 32'(err), 32'(e[32]));
        check($sformatf("v%0d_rdata", k), rdata, e[31:0]);
        check($sformatf("v%0d_adr", k), mem_Adr, 32'(v.addr[6:2]));
        check($sformatf("v%0d_writes", k), 32'(wr_cnt - wr0), 32'(v.writes));
        if (v.chk_idx >= 0) begin
            check($sformatf("v%0d_memword", k), mem[v.chk_idx], v.chk_word);
        end
    endtask

    task automatic run_held(input logic [1:0] sz, input logic [31:0] a, input int exp_done,
                            input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int   n_done = 0;
        int   consec = 0;
        logic prev   = 1'b0;
        wait_idle();
        req   = 1'b1;
        we    = 1'b0;
        size  = sz;
        uns   = 1'b0;
        addr  = a;
        wdata = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                check({tag, "_err"}, 32'(err), 32'(exp_err));
                check({tag, "_rdata"}, rdata, exp_rd);
            end
            if (done && prev) begin
                consec++;
            end
            prev = done;
        end
        req = 1'b0;
        check({tag, "_done_count"}, 32'(n_done), 32'(exp_done));
        check({tag, "_consecutive_done"}, 32'(consec), 32'd0);
    endtask

    // Stimulus
    initial begin
        vt[0]  = mk(0, 2'b00, 0, 32'h0F, 32'h0,         3, 0, 32'hFFFF_FF80, 0, -1, 32'h0);
        vt[1]  = mk(0, 2'b00, 1, 32'h0E, 32'h0,         3, 0, 32'h0000_00FF, 0, -1, 32'h0);
        vt[2]  = mk(0, 2'b01, 0, 32'h0E, 32'h0,         3, 0, 32'hFFFF_80FF, 0, -1, 32'h0);
        vt[3]  = mk(0, 2'b01, 1, 32'h0C, 32'h0,         3, 0, 32'h0000_1234, 0, -1, 32'h0);
        vt[4]  = mk(0, 2'b10, 0, 32'h0C, 32'h0,         3, 0, 32'h80FF_1234, 0, -1, 32'h0);
        vt[5]  = mk(1, 2'b01, 0, 32'h0E, 32'hFFFF_ABCD, 4, 0, 32'h80FF_1234, 1, 3, 32'hABCD_1234);
        vt[6]  = mk(1, 2'b00, 0, 32'h15, 32'h0000_00AA, 4, 0, 32'h80FF_1234, 1, 5, 32'h0123_AA67);
        vt[7]  = mk(1, 2'b10, 0, 32'h7C, 32'hDEAD_BEEF, 2, 0, 32'h80FF_1234, 1, 31, 32'hDEAD_BEEF);
        vt[8]  = mk(0, 2'b10, 0, 32'h7C, 32'h0,         3, 0, 32'hDEAD_BEEF, 0, -1, 32'h0);
        vt[9]  = mk(1, 2'b10, 0, 32'h06, 32'h5555_5555, 1, 1, 32'hDEAD_BEEF, 0, 1, 32'h1111_1111);
        vt[10] = mk(0, 2'b10, 0, 32'h80, 32'h0,         1, 1, 32'hDEAD_BEEF, 0, -1, 32'h0);
        vt[11] = mk(0, 2'b11, 0, 32'h0C, 32'h0,         1, 1, 32'hDEAD_BEEF, 0, -1, 32'h0);
        vt[12] = mk(1, 2'b01, 0, 32'h0D, 32'h0000_7777, 1, 1, 32'hDEAD_BEEF, 0, 3, 32'hABCD_1234);
        vt[13] = mk(0, 2'b00, 0, 32'h0D, 32'h0,         3, 0, 32'h0000_0012, 0, -1, 32'h0);
        vt[14] = mk(0, 2'b01, 0, 32'h16, 32'h0,         3, 0, 32'h0000_0123, 0, -1, 32'h0);
        vt[15] = mk(0, 2'b00, 0, 32'h15, 32'h0,         3, 0, 32'hFFFF_FFAA, 0, -1, 32'h0);

        // Preload memory through the backdoor while the unit is held in reset.
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bd_we   = 1'b1;
            bd_idx  = 5'(i);
            bd_data = init_word(i);
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        check("rst_rdata", rdata, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(mem_WrEn), 32'd0);
        check("rst_adr", mem_Adr, 32'h0);
        check("rst_datain", mem_DataIn, 32'h0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 16; k++) begin
            run_vec(vt[k], k);
        end

        // Reset landing in the WR cycle of a word store to word 2.
        wait_idle();
        req   = 1'b1;
        we    = 1'b1;
        size  = 2'b10;
        uns   = 1'b0;
        addr  = 32'h08;
        wdata = 32'h9999_9999;
        @(posedge clk); #1;
        req = 1'b0;
        check("midwr_wren_before_rst", 32'(mem_WrEn), 32'd1);
        rst = 1'b1;
        #1;
        check("midwr_wren_forced", 32'(mem_WrEn), 32'd0);
        @(posedge clk); #1;
        check("midwr_busy", 32'(busy), 32'd0);
        check("midwr_rdata", rdata, 32'h0);
        check("midwr_done", 32'(done), 32'd0);
        check("midwr_adr", mem_Adr, 32'h0);
        check("midwr_state", 32'(dbg_state), 32'd0);
        check("midwr_word2", mem[2], 32'h2222_2222);
        rst = 1'b0;
        @(posedge clk); #1;

        // Requests held high across whole accesses.
        run_held(2'b10, 32'h0C, 4, 1'b0, 32'hABCD_1234, "held_load");
        run_held(2'b11, 32'h0C, 8, 1'b1, 32'hABCD_1234, "held_illegal");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
